scr1_tcm_uart_loader: RTL and testbench

Boot loader that fills the TCM dual-port memory through its write port (port B) from a UART byte stream before the core starts. It parses a framed image (sync, length, little-endian payload, checksum) and assembles 32-bit words. It issues one full-word write per word at sequential word addresses. It holds the core in reset until a frame completes with a good checksum.

---
 rtl/scr1_tcm_loader_pkg.sv | 32 +++
 rtl/scr1_tcm_uart_loader.sv | 203 ++++++++++++++++++++
 tb/tb_scr1_tcm_uart_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_tcm_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : scr1_tcm_loader_pkg
//  Description : Shared types and constants for the TCM UART boot loader:
//                loader FSM state encoding, default frame sync byte,
//                checksum and length-field widths, busy-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package scr1_tcm_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_LEN0 = 3'd1,
    LDR_LEN1 = 3'd2,
    LDR_DATA = 3'd3,
    LDR_CSUM = 3'd4,
    LDR_DONE = 3'd5,
    LDR_ERR  = 3'd6
  } ldr_state_e;

  localparam logic [7:0]  c_SYNC_BYTE_DFLT = 8'hA5;
  localparam int unsigned c_CSUM_W         = 8;
  localparam int unsigned c_LEN_W          = 16;

  // States in which a frame is being received (timeout armed, ld_busy high).
  function automatic logic ldr_is_busy(input ldr_state_e s);
    return (s == LDR_LEN0) || (s == LDR_LEN1) || (s == LDR_DATA) || (s == LDR_CSUM);
  endfunction

endpackage : scr1_tcm_loader_pkg
`default_nettype wire

// File: rtl/scr1_tcm_uart_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : scr1_tcm_uart_loader
//  Description : Boot loader filling the TCM through write port B from a UART
//                byte stream. Frame: SYNC, N[7:0], N[15:8], 4*N payload bytes
//                (little-endian words), 8-bit sum checksum. Holds the core in
//                reset until a frame completes with a good checksum.
//  Ports       : clk, rst (async, active-high)
//                rx_data/rx_vld       - received byte + one-cycle strobe
//                mem_wen/webb/addr/data - TCM port B full-word write
//                ld_busy/ld_done/ld_err - loader status
//                core_hold             - core reset request
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_tcm_uart_loader
  import scr1_tcm_loader_pkg::*;
#(
  parameter int unsigned SCR1_SIZE   = 32'h00010000,
  parameter logic [7:0]  SYNC_BYTE   = c_SYNC_BYTE_DFLT,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_vld,
  output logic                            mem_wen,
  output logic [3:0]                      mem_webb,
  output logic [$clog2(SCR1_SIZE)-1:2]    mem_addr,
  output logic [31:0]                     mem_data,
  output logic                            ld_busy,
  output logic                            ld_done,
  output logic                            ld_err,
  output logic                            core_hold
);

  localparam int unsigned AW        = $clog2(SCR1_SIZE) - 2;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] MAX_WORDS = 32'(SCR1_SIZE / 4);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

  ldr_state_e            state_q, state_d;
  logic [c_LEN_W-1:0]    len_q, len_d;
  logic [c_LEN_W-1:0]    wcnt_q, wcnt_d;     // words written in this frame
  logic [1:0]            bcnt_q, bcnt_d;     // byte position inside word
  logic [23:0]           word_q, word_d;     // first three bytes of a word
  logic [c_CSUM_W-1:0]   csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  wen_q, wen_d;
  logic [3:0]            webb_q, webb_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  hold_q, hold_d;

  logic [c_LEN_W-1:0]    len_full;
  logic [c_LEN_W-1:0]    wcnt_inc;

  assign len_full = {rx_data, len_q[7:0]};
  assign wcnt_inc = wcnt_q + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LDR_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      wen_q   <= 1'b0;
      webb_q  <= 4'h0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      wen_q   <= wen_d;
      webb_q  <= webb_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;

    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (rx_vld && (rx_data == SYNC_BYTE)) begin
          state_d = LDR_LEN0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          wcnt_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
        end
      end
      LDR_LEN0: begin
        if (rx_vld) begin
          len_d   = {len_q[15:8], rx_data};
          state_d = LDR_LEN1;
        end
      end
      LDR_LEN1: begin
        if (rx_vld) begin
          len_d = len_full;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = LDR_ERR;
            err_d   = 1'b1;
          end else if (len_full == '0) begin
            state_d = LDR_CSUM;
          end else begin
            state_d = LDR_DATA;
          end
        end
      end
      LDR_DATA: begin
        if (rx_vld) begin
          csum_d = csum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;
          // Shift in from the top so the first byte ends up in bits [7:0].
          word_d = {rx_data, word_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wen_d  = 1'b1;
            addr_d = AW'(wcnt_q);
            data_d = {rx_data, word_q};
            wcnt_d = wcnt_inc;
            if (wcnt_inc == len_q) begin
              state_d = LDR_CSUM;
            end
          end
        end
      end
      LDR_CSUM: begin
        if (rx_vld) begin
          if (rx_data == csum_q) begin
            state_d = LDR_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = LDR_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = LDR_IDLE;
    endcase

    // Idle-gap watchdog: an arriving byte always takes priority, so expiry
    // only applies on cycles without rx_vld.
    if (ldr_is_busy(state_q) && !rx_vld) begin
      if (tmo_q == TMO_LIMIT) begin
        state_d = LDR_ERR;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    webb_d = {4{wen_d}};
    busy_d = ldr_is_busy(state_d);
  end

  assign mem_wen   = wen_q;
  assign mem_webb  = webb_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign ld_busy   = busy_q;
  assign ld_done   = done_q;
  assign ld_err    = err_q;
  assign core_hold = hold_q;

endmodule : scr1_tcm_uart_loader
`default_nettype wire

// File: tb/tb_scr1_tcm_uart_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_scr1_tcm_uart_loader
//  Description : Self-checking bench for scr1_tcm_uart_loader: reset values,
//                table of framed images with expected writes/status, timeout
//                and mid-frame reset sequences, and random frames checked
//                against a byte-level frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_tcm_uart_loader;

  localparam int unsigned SIZE = 32'h00010000;
  localparam int unsigned TMO  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        mem_wen;
  logic [3:0]  mem_webb;
  logic [15:2] mem_addr;
  logic [31:0] mem_data;
  logic        ld_busy, ld_done, ld_err, core_hold;

  always #5 clk = ~clk;

  scr1_tcm_uart_loader #(
    .SCR1_SIZE  (SIZE),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_vld   (rx_vld),
    .mem_wen  (mem_wen),
    .mem_webb (mem_webb),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .core_hold(core_hold)
  );

  int total = 0;
  int bad   = 0;

  // Write capture and port-B protocol watch.
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          webb_bad  = 0;
  int          pulse_bad = 0;
  logic        prev_wen  = 1'b0;

  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_data);
    end
    if (mem_webb !== ((mem_wen === 1'b1) ? 4'hF : 4'h0)) webb_bad++;
    if ((mem_wen === 1'b1) && prev_wen) pulse_bad++;
    prev_wen = (mem_wen === 1'b1);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send(input logic [7:0] b);
    rx_vld  = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_wr();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp_d[$]);
    chk($sformatf("%s_nwr", tag), wr_data_q.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < wr_data_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_d[i]);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, ld_done, d);
    chk({tag, "_err"},  ld_err,  e);
    chk({tag, "_hold"}, core_hold, h);
    chk({tag, "_busy"}, ld_busy, 1'b0);
  endtask

  typedef struct {
    int          nb;
    logic [95:0] b;      // byte k at bits [95-8k -: 8]
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        done;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int nb, input logic [95:0] b, input int nwr,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic d, input logic e, input logic h);
    vec_t v;
    v.nb = nb; v.b = b; v.nwr = nwr; v.w0 = w0; v.w1 = w1;
    v.done = d; v.err = e; v.hold = h;
    tbl.push_back(v);
  endfunction

  initial begin
    vec_t        v;
    logic        synced;
    logic [7:0]  bb;
    logic [31:0] exp_d[$];
    logic [7:0]  p[$];
    logic [7:0]  fr[$];
    int          n, mode, sum, gap;
    logic        good;
    logic [15:0] len;

    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen",  mem_wen, 1'b0);
    chk("rst_webb", mem_webb, 4'h0);
    chk("rst_addr", mem_addr, 14'h0);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_busy", ld_busy, 1'b0);
    chk("rst_done", ld_done, 1'b0);
    chk("rst_err",  ld_err, 1'b0);
    chk("rst_hold", core_hold, 1'b1);
    rst = 1'b0;
    idle(2);

    // ---------------- table-driven frames ----------------
    add(12, {8'hA5,8'h02,8'h00,8'h13,8'h06,8'h40,8'h01,8'h6F,8'hF0,8'hDF,8'hFE,8'h96},
        2, 32'h01400613, 32'hFEDFF06F, 1'b1, 1'b0, 1'b0);
    add(12, {8'hA5,8'h02,8'h00,8'h13,8'h06,8'h40,8'h01,8'h6F,8'hF0,8'hDF,8'hFE,8'h97},
        2, 32'h01400613, 32'hFEDFF06F, 1'b0, 1'b1, 1'b1);
    add(3,  {8'hA5,8'h01,8'h40,72'h0}, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    add(4,  {8'hA5,8'h00,8'h00,8'h00,64'h0}, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    add(10, {8'h00,8'hFF,8'hA5,8'h01,8'h00,8'hAA,8'hBB,8'hCC,8'hDD,8'h0E,16'h0},
        1, 32'hDDCCBBAA, 32'h0, 1'b1, 1'b0, 1'b0);
    add(12, {8'hA5,8'h02,8'h00,8'h13,8'h06,8'h40,8'h01,8'h6F,8'hF0,8'hDF,8'hFE,8'h96},
        2, 32'h01400613, 32'hFEDFF06F, 1'b1, 1'b0, 1'b0);
    add(4,  {8'hA5,8'h00,8'h00,8'h01,64'h0}, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      synced = 1'b0;
      clear_wr();
      for (int k = 0; k < v.nb; k++) begin
        bb = v.b[95-8*k -: 8];
        send(bb);
        if (!synced && bb == 8'hA5) begin
          synced = 1'b1;
          chk($sformatf("t%0d_sync_hold", i), core_hold, 1'b1);
          chk($sformatf("t%0d_sync_busy", i), ld_busy, 1'b1);
          chk($sformatf("t%0d_sync_done", i), ld_done, 1'b0);
          chk($sformatf("t%0d_sync_err", i),  ld_err, 1'b0);
        end
      end
      idle(2);
      exp_d.delete();
      if (v.nwr > 0) exp_d.push_back(v.w0);
      if (v.nwr > 1) exp_d.push_back(v.w1);
      check_writes($sformatf("t%0d", i), exp_d);
      check_status($sformatf("t%0d", i), v.done, v.err, v.hold);
    end

    // ---------------- timeout after 2 payload bytes ----------------
    clear_wr();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TMO);
    chk("tmo_edge_busy", ld_busy, 1'b1);
    chk("tmo_edge_err",  ld_err, 1'b0);
    idle(1);
    chk("tmo_err",  ld_err, 1'b1);
    chk("tmo_busy", ld_busy, 1'b0);
    chk("tmo_hold", core_hold, 1'b1);
    chk("tmo_nwr",  wr_data_q.size(), 0);
    // Recovery frame; a byte arriving exactly when the counter expires wins.
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(TMO);
    send(8'h33); send(8'h44); send(8'hAA);
    idle(2);
    exp_d.delete();
    exp_d.push_back(32'h44332211);
    check_writes("tmo_rec", exp_d);
    check_status("tmo_rec", 1'b1, 1'b0, 1'b0);

    // ---------------- maximum length, write timing, mid-frame reset ----------------
    clear_wr();
    send(8'hA5); send(8'h00); send(8'h40);
    chk("max_len_busy", ld_busy, 1'b1);
    chk("max_len_err",  ld_err, 1'b0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("wr_wen",  mem_wen, 1'b1);
    chk("wr_webb", mem_webb, 4'hF);
    chk("wr_addr", mem_addr, 14'h0);
    chk("wr_data", mem_data, 32'h44332211);
    send(8'h55);
    chk("wr_pulse_end", mem_wen, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_wen",  mem_wen, 1'b0);
    chk("arst_webb", mem_webb, 4'h0);
    chk("arst_addr", mem_addr, 14'h0);
    chk("arst_data", mem_data, 32'h0);
    chk("arst_busy", ld_busy, 1'b0);
    chk("arst_done", ld_done, 1'b0);
    chk("arst_err",  ld_err, 1'b0);
    chk("arst_hold", core_hold, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h66); send(8'h77); send(8'h88); send(8'h99); send(8'h12);
    idle(2);
    chk("arst_nwr",  wr_data_q.size(), 1);
    chk("arst_hold2", core_hold, 1'b1);
    chk("arst_busy2", ld_busy, 1'b0);

    // ---------------- random frames vs. frame model ----------------
    for (int it = 0; it < 25; it++) begin
      fr.delete(); p.delete(); exp_d.delete();
      mode = int'($urandom_range(0, 7));
      n    = int'($urandom_range(0, 5));
      if (mode == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
          bb = 8'($urandom_range(0, 255));
          if (bb == 8'hA5) bb = 8'h00;
          fr.push_back(bb);
        end
      end
      fr.push_back(8'hA5);
      if (mode == 1) begin
        len = 16'h4001 + 16'($urandom_range(0, 16'h3FFE));
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        good = 1'b0;
      end else begin
        len = 16'(n);
        fr.push_back(len[7:0]);
        fr.push_back(len[15:8]);
        sum = 0;
        for (int j = 0; j < 4 * n; j++) begin
          p.push_back(8'($urandom_range(0, 255)));
          sum = (sum + int'(p[j])) % 256;
          fr.push_back(p[j]);
        end
        for (int w = 0; w < n; w++)
          exp_d.push_back({p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]});
        good = ($urandom_range(0, 3) != 0);
        fr.push_back(good ? 8'(sum) : 8'((sum + int'($urandom_range(1, 255))) % 256));
      end
      clear_wr();
      foreach (fr[k]) begin
        gap = ($urandom_range(0, 15) == 0) ? int'(TMO) : int'($urandom_range(0, 2));
        idle(gap);
        send(fr[k]);
      end
      idle(2);
      check_writes($sformatf("r%0d", it), exp_d);
      check_status($sformatf("r%0d", it), good, !good, !good);
    end

    chk("webb_protocol", webb_bad, 0);
    chk("wen_single_cycle", pulse_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_scr1_tcm_uart_loader
`default_nettype wire
